// File: rtl/cs42448_tdm_port.sv
// CS42448 serial audio port: MCLK/SCLK/LRCK generation, TDM or I2S DAC serialiser and ADC
// deserialiser. Define CS42448_TDM_LOOPBACK_EN to feed the internal SDOUT into the RX path.
module cs42448_tdm_port #(
  parameter int unsigned CH_NUM   = 8,
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned MCLK_DIV = 1,
  parameter int unsigned FS_MODE  = 1
) (
  input  logic                         sys_clk,
  input  logic                         sys_nrst,
  input  logic                         enable,
  input  logic [CH_NUM*SAMPLE_W-1:0]   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         tx_underrun,
  output logic [CH_NUM*SAMPLE_W-1:0]   rx_data,
  output logic                         rx_valid,
  output logic                         CS42xx8_MCLK,
  output logic                         CS42xx8_SCLK,
  output logic                         CS42xx8_LRCK,
  output logic                         CS42xx8_SDOUT,
  input  logic                         CS42xx8_SDIN
);

  localparam int unsigned FrameW = CH_NUM * SAMPLE_W;
  localparam int unsigned ScW    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned McW    = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam int unsigned PosW   = $clog2(SLOT_W);
  localparam int unsigned SlotW  = $clog2(CH_NUM);

  localparam logic [ScW-1:0]   SclkTc   = ScW'(SCLK_DIV - 1);
  localparam logic [McW-1:0]   MclkTc   = McW'(MCLK_DIV - 1);
  localparam logic [PosW-1:0]  PosLast  = PosW'(SLOT_W - 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(CH_NUM - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [McW-1:0]     mclk_cnt_q;
  logic               mclk_q;
  logic [ScW-1:0]     sclk_cnt_q, sclk_cnt_d;
  logic               sclk_q, sclk_d;
  logic [PosW-1:0]    pos_q, pos_d;
  logic [SlotW-1:0]   slot_q, slot_d;
  logic               lrck_q, lrck_d;
  logic               sdout_q, sdout_d;
  logic [FrameW-1:0]  tx_frame_q, tx_frame_d;
  logic [FrameW-1:0]  hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               underrun_q, underrun_d;
  logic [FrameW-1:0]  rx_shift_q, rx_shift_d;
  logic [FrameW-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               load;
  logic               capture;
  logic               frame_end;
  logic               rx_bit;

`ifdef CS42448_TDM_LOOPBACK_EN
  assign rx_bit = sdout_q;
`else
  assign rx_bit = CS42xx8_SDIN;
`endif

  // Positions 1..SAMPLE_W of a slot carry sample bits; position 0 is the one-SCLK delay bit.
  function automatic logic data_pos(input logic [PosW-1:0] p);
    return (p != '0) && (p <= PosW'(SAMPLE_W));
  endfunction

  function automatic logic lrck_at(input logic [SlotW-1:0] s, input logic [PosW-1:0] p);
    if (FS_MODE != 0) return (s == '0) && (p == '0);
    return s == SlotW'(1);
  endfunction

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      mclk_cnt_q <= '0;
      mclk_q     <= 1'b0;
    end else if (mclk_cnt_q == MclkTc) begin
      mclk_cnt_q <= '0;
      mclk_q     <= ~mclk_q;
    end else begin
      mclk_cnt_q <= mclk_cnt_q + 1'b1;
    end
  end

  assign frame_end = (slot_q == SlotLast) && (pos_q == PosLast);
  assign capture   = tx_valid && !hold_valid_q;

  always_comb begin
    state_d    = state_q;
    sclk_cnt_d = sclk_cnt_q;
    sclk_d     = sclk_q;
    pos_d      = pos_q;
    slot_d     = slot_q;
    lrck_d     = lrck_q;
    sdout_d    = sdout_q;
    tx_frame_d = tx_frame_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          load    = 1'b1;
          lrck_d  = lrck_at('0, '0);
        end
      end
      StRun: begin
        if (!enable) begin
          state_d    = StIdle;
          sclk_cnt_d = '0;
          sclk_d     = 1'b0;
          pos_d      = '0;
          slot_d     = '0;
          lrck_d     = 1'b0;
          sdout_d    = 1'b0;
          tx_frame_d = '0;
          rx_shift_d = '0;
        end else if (sclk_cnt_q != SclkTc) begin
          sclk_cnt_d = sclk_cnt_q + 1'b1;
        end else begin
          sclk_cnt_d = '0;
          sclk_d     = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: sample the ADC line.
            if (data_pos(pos_q)) rx_shift_d = {rx_shift_q[FrameW-2:0], rx_bit};
            if (frame_end) begin
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
            end
          end else begin
            // Falling edge: advance the bit counter, then drive SDOUT/LRCK for the new position.
            if (frame_end) begin
              pos_d  = '0;
              slot_d = '0;
              load   = 1'b1;
            end else if (pos_q == PosLast) begin
              pos_d  = '0;
              slot_d = slot_q + 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
            sdout_d = 1'b0;
            if (data_pos(pos_d)) begin
              sdout_d    = tx_frame_q[FrameW-1];
              tx_frame_d = {tx_frame_q[FrameW-2:0], 1'b0};
            end
            lrck_d = lrck_at(slot_d, pos_d);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A word captured in the load cycle is not yet visible here, so it waits one frame.
    if (load) begin
      tx_frame_d = hold_valid_q ? hold_q : '0;
      underrun_d = ~hold_valid_q;
    end
  end

  assign hold_valid_d = capture | (hold_valid_q & ~load);
  assign hold_d       = capture ? tx_data : hold_q;

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q      <= StIdle;
      sclk_cnt_q   <= '0;
      sclk_q       <= 1'b0;
      pos_q        <= '0;
      slot_q       <= '0;
      lrck_q       <= 1'b0;
      sdout_q      <= 1'b0;
      tx_frame_q   <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_cnt_q   <= sclk_cnt_d;
      sclk_q       <= sclk_d;
      pos_q        <= pos_d;
      slot_q       <= slot_d;
      lrck_q       <= lrck_d;
      sdout_q      <= sdout_d;
      tx_frame_q   <= tx_frame_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      underrun_q   <= underrun_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  assign tx_ready      = ~hold_valid_q;
  assign tx_underrun   = underrun_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign CS42xx8_MCLK  = mclk_q;
  assign CS42xx8_SCLK  = sclk_q;
  assign CS42xx8_LRCK  = lrck_q;
  assign CS42xx8_SDOUT = sdout_q;

endmodule

// File: tb/tb_cs42448_tdm_port.sv
// Bench for cs42448_tdm_port: a TDM instance (defaults) and an I2S instance, SDOUT wired to SDIN,
// expected bit streams and RX frames queued at stimulus time and checked as the DUT produces them.
module tb_cs42448_tdm_port;

  localparam int SclkDiv   = 2;
  localparam int FrameBits = 256;

  logic         clk = 1'b0;
  logic         sys_nrst;
  logic         enable0, tx_valid0, tx_ready0, tx_underrun0, rx_valid0;
  logic [191:0] tx_data0, rx_data0;
  logic         mclk0, sclk0, lrck0, sdout0, sdin0;
  logic         enable1, tx_valid1, tx_ready1, tx_underrun1, rx_valid1;
  logic [47:0]  tx_data1, rx_data1;
  logic         mclk1, sclk1, lrck1, sdout1, sdin1;

  int vectors = 0;
  int miscompares = 0;
  int ur_cnt = 0;
  int rx_cnt0 = 0;
  int rx_cnt1 = 0;
  bit prev0 = 0, prev1 = 0, rise0 = 0, rise1 = 0;
  logic [1:0]   bit_q[$];
  logic [191:0] rx_q0[$];
  logic [191:0] rx_q1[$];

  logic [191:0] fr_a, fr_b, fr_e, fr_g, fr_h, fr_i2s;

  assign sdin0 = sdout0;
  assign sdin1 = sdout1;

  always #5 clk = ~clk;

  cs42448_tdm_port dut (
    .sys_clk(clk), .sys_nrst(sys_nrst), .enable(enable0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .tx_underrun(tx_underrun0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .CS42xx8_MCLK(mclk0), .CS42xx8_SCLK(sclk0), .CS42xx8_LRCK(lrck0),
    .CS42xx8_SDOUT(sdout0), .CS42xx8_SDIN(sdin0)
  );

  cs42448_tdm_port #(.CH_NUM(2), .FS_MODE(0)) dut_i2s (
    .sys_clk(clk), .sys_nrst(sys_nrst), .enable(enable1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .tx_underrun(tx_underrun1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .CS42xx8_MCLK(mclk1), .CS42xx8_SCLK(sclk1), .CS42xx8_LRCK(lrck1),
    .CS42xx8_SDOUT(sdout1), .CS42xx8_SDIN(sdin1)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {lrck, sdout} expected at the SCLK rise for bit counter value bc.
  function automatic logic [1:0] model_bit(input int inst, input logic [191:0] fr, input int bc);
    int ch, slot, p;
    logic sd, lr;
    ch   = (inst == 0) ? 8 : 2;
    slot = bc / 32;
    p    = bc % 32;
    sd   = 1'b0;
    if (p >= 1 && p <= 24) sd = fr[(ch - 1 - slot) * 24 + 24 - p];
    lr = (inst == 0) ? (bc == 0) : (slot == 1);
    return {lr, sd};
  endfunction

  task automatic tick();
    logic [191:0] e;
    @(posedge clk);
    #1;
    rise0 = sclk0 && !prev0;
    prev0 = sclk0;
    rise1 = sclk1 && !prev1;
    prev1 = sclk1;
    if (tx_underrun0) ur_cnt++;
    if (rx_valid0) begin
      rx_cnt0++;
      vectors++;
      assert (rx_q0.size() > 0) else begin
        miscompares++;
        $error("FAIL rx0_unexpected: observed rx_valid with frame %0h, expected none", rx_data0);
      end
      if (rx_q0.size() > 0) begin
        e = rx_q0.pop_front();
        chkw("rx0_frame", rx_data0, e);
      end
    end
    if (rx_valid1) begin
      rx_cnt1++;
      vectors++;
      assert (rx_q1.size() > 0) else begin
        miscompares++;
        $error("FAIL rx1_unexpected: observed rx_valid with frame %0h, expected none", rx_data1);
      end
      if (rx_q1.size() > 0) begin
        e = rx_q1.pop_front();
        chkw("rx1_frame", 192'(rx_data1), e);
      end
    end
  endtask

  task automatic wait_rise(input int inst);
    int n = 0;
    bit r;
    do begin
      tick();
      n++;
      r = (inst == 0) ? rise0 : rise1;
    end while (!r && n < 8 * SclkDiv);
    if (!r) begin
      miscompares++;
      $display("FAIL rise_timeout: observed no SCLK rise in %0d cycles, expected one", n);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  endtask

  task automatic offer0(input logic [191:0] w);
    tx_data0  = w;
    tx_valid0 = 1'b1;
    tick();
    tx_valid0 = 1'b0;
  endtask

  task automatic run_frame(input int inst, input logic [191:0] fr, input int nbits,
                           input bit exp_rx, input bit offer, input logic [191:0] offer_word);
    logic [1:0] e;
    for (int b = 0; b < nbits; b++) bit_q.push_back(model_bit(inst, fr, b));
    if (exp_rx) begin
      if (inst == 0) rx_q0.push_back(fr);
      else rx_q1.push_back(fr);
    end
    for (int b = 0; b < nbits; b++) begin
      wait_rise(inst);
      e = bit_q.pop_front();
      chk1($sformatf("lrck%0d_bc%0d", inst, b), (inst == 0) ? lrck0 : lrck1, e[1]);
      chk1($sformatf("sdout%0d_bc%0d", inst, b), (inst == 0) ? sdout0 : sdout1, e[0]);
      if (b == 0 && offer) offer0(offer_word);
    end
  endtask

  initial begin
    fr_a = {24'h800001, 24'h123456, 24'hABCDEF, 24'h0F0F0F,
            24'hF0F0F0, 24'h000001, 24'hFFFFFF, 24'h7FFFFE};
    fr_b = {8{24'h123456}};
    fr_e = {24'hC0FFEE, 24'h000000, 24'h0000FF, 24'hFF0000,
            24'h5A5A5A, 24'hA5A5A5, 24'h010203, 24'h800000};
    fr_g = {8{24'h3C3C3C}};
    fr_h = {8{24'h111111}};
    fr_i2s = {144'h0, 24'hAAAAAA, 24'h555555};
    sys_nrst = 1'b0;
    enable0 = 1'b0; tx_valid0 = 1'b0; tx_data0 = '0;
    enable1 = 1'b0; tx_valid1 = 1'b0; tx_data1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_tx_ready", tx_ready0, 1'b1);
    chk1("reset_mclk", mclk0, 1'b0);
    sys_nrst = 1'b1;

    // Idle after reset.
    chk1("idle_tx_underrun", tx_underrun0, 1'b0);
    chk1("idle_rx_valid", rx_valid0, 1'b0);
    chkw("idle_rx_data", rx_data0, '0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk1($sformatf("mclk_c%0d", i), mclk0, i[0]);
      chk1($sformatf("idle_sclk_c%0d", i), sclk0, 1'b0);
      chk1($sformatf("idle_lrck_c%0d", i), lrck0, 1'b0);
      chk1($sformatf("idle_sdout_c%0d", i), sdout0, 1'b0);
    end

    // TDM frame A, then frame B (loopback pattern) offered during A.
    offer0(fr_a);
    chk1("hold_full_ready", tx_ready0, 1'b0);
    enable0 = 1'b1;
    tick();
    chk1("load_a_ready", tx_ready0, 1'b1);
    chk1("load_a_underrun", tx_underrun0, 1'b0);
    run_frame(0, fr_a, FrameBits, 1'b1, 1'b1, fr_b);
    chk1("a_no_underrun", ur_cnt == 0, 1'b1);
    run_frame(0, fr_b, FrameBits, 1'b1, 1'b0, '0);

    // Underrun frame C; capture E exactly in the load cycle of frame D.
    run_frame(0, '0, FrameBits, 1'b1, 1'b0, '0);
    chk1("c_underrun_count", ur_cnt == 1, 1'b1);
    repeat (SclkDiv - 1) tick();
    tx_data0  = fr_e;
    tx_valid0 = 1'b1;
    tick();
    tx_valid0 = 1'b0;
    chk1("d_load_underrun", tx_underrun0, 1'b1);
    chk1("d_load_captured", tx_ready0, 1'b0);
    run_frame(0, '0, FrameBits, 1'b1, 1'b0, '0);
    run_frame(0, fr_e, FrameBits, 1'b1, 1'b0, '0);

    // Frame F underruns; G is held while the port is disabled at bc=100.
    run_frame(0, '0, 101, 1'b0, 1'b1, fr_g);
    enable0 = 1'b0;
    tick();
    chk1("dis_sclk", sclk0, 1'b0);
    chk1("dis_lrck", lrck0, 1'b0);
    chk1("dis_sdout", sdout0, 1'b0);
    chk1("dis_hold_kept", tx_ready0, 1'b0);
    repeat (40) tick();
    chk1("dis_no_rx_valid", rx_cnt0 == 5, 1'b1);
    chkw("dis_rx_data_kept", rx_data0, fr_e);
    enable0 = 1'b1;
    tick();
    chk1("reen_underrun", tx_underrun0, 1'b0);
    chk1("reen_ready", tx_ready0, 1'b1);
    run_frame(0, fr_g, FrameBits, 1'b1, 1'b0, '0);
    enable0 = 1'b0;
    tick();
    chk1("tdm_rx_count", rx_cnt0 == 6, 1'b1);
    chk1("tdm_underrun_count", ur_cnt == 3, 1'b1);
    chk1("tdm_rx_queue_empty", rx_q0.size() == 0, 1'b1);

    // I2S instance: left 0xAAAAAA, right 0x555555.
    tx_data1  = fr_i2s[47:0];
    tx_valid1 = 1'b1;
    tick();
    tx_valid1 = 1'b0;
    enable1   = 1'b1;
    tick();
    run_frame(1, fr_i2s, 64, 1'b1, 1'b0, '0);
    enable1 = 1'b0;
    tick();
    chk1("i2s_rx_count", rx_cnt1 == 1, 1'b1);

    // Asynchronous reset mid-frame.
    enable0 = 1'b1;
    tick();
    offer0(fr_h);
    repeat (3) wait_rise(0);
    #2;
    sys_nrst = 1'b0;
    #1;
    chk1("areset_sclk", sclk0, 1'b0);
    chk1("areset_lrck", lrck0, 1'b0);
    chk1("areset_ready", tx_ready0, 1'b1);
    chkw("areset_rx_data", rx_data0, '0);
    enable0 = 1'b0;
    #10;
    sys_nrst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
